fetch_pc_unit: RTL
==================

Name: fetch_pc_unit

Overview:
Instruction-fetch stage directly downstream of the branch resolver. Consumes its pc_sel/if_kill/dec_kill outputs and produces the program counter. Issues instruction-memory requests (at most one outstanding) and buffers returned instructions in a 2-entry queue toward decode. Discards responses from squashed fetches.

Parameters:
XLEN, 32, address/instruction width
RESET_PC, 32'h0000_0200, first fetch address after reset
QDEPTH, 2, instruction-queue entries (fixed 2; larger values not supported)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
pc_sel  input  2  Bundle PcSel: PC_4=0, PC_BRJMP=1, PC_JALR=2, PC_EXC=3
if_kill  input  1  squash in-flight fetch
dec_kill  input  1  flush instruction queue
br_target  input  XLEN  target for PC_BRJMP
jalr_target  input  XLEN  target for PC_JALR
exc_target  input  XLEN  target for PC_EXC
imem_req_valid  output  1  fetch request
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  XLEN  fetch address
imem_res_valid  input  1  response strobe, one per accepted request, ≥1 cycle after acceptance
imem_res_data  input  XLEN  instruction word
dec_valid  output  1  queue head valid
dec_ready  input  1  decode consumes head
dec_inst  output  XLEN  head instruction
dec_pc  output  XLEN  head PC

Behaviour:
- Reset (async, rst_n=0): fetch_pc=RESET_PC, state=S_BOOT, queue empty, outstanding=0; imem_req_valid=0, imem_req_addr=RESET_PC, dec_valid=0, dec_inst=0, dec_pc=0. Reset mid-transaction drops any pending response; no response counted after reset release.
- States: S_BOOT (one idle cycle after reset release) -> S_FETCH. S_FETCH: imem_req_valid=1 when no redirect this cycle and (queue_count + outstanding) < 2; imem_req_addr=fetch_pc. Handshake (valid&&ready): req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (wraps mod 2^XLEN), -> S_WAIT. S_WAIT: no new request; on imem_res_valid push {imem_res_data, req_pc} -> S_FETCH. S_DROP: outstanding response must be discarded; on imem_res_valid discard -> S_FETCH.
- Redirect = (pc_sel != PC_4). Registered: fetch_pc <= selected target at the edge; imem_req_valid forced 0 combinationally that cycle. If in S_WAIT (or a request handshakes in the same cycle), next state S_DROP. Response arriving in the redirect cycle is discarded.
- if_kill with pc_sel==PC_4 (imem not valid): no PC change; in-flight response still kept (if_kill only squashes on redirect). if_kill with redirect: as redirect.
- dec_kill: queue cleared at the edge; simultaneous push in that cycle is discarded; pop ignored.
- Queue: FIFO, dec_valid = count!=0, dec_inst/dec_pc = head (0 when empty). Pop on dec_valid&&dec_ready. Push and pop same cycle legal, count unchanged. Issue rule guarantees no push on full; push on full is an assertion failure.
- Latency: reset release -> first imem_req_valid in cycle 2; response cycle N -> dec_valid cycle N+1.
- Targets used as given; no alignment check.

Optional Feature:
FETCH_PERF_EN: defined -> adds outputs perf_fetched[31:0] (increments per response pushed into the queue) and perf_dropped[31:0] (increments per discarded response, incl. dec_kill-discarded pushes); both reset to 0, wrap at 2^32. Undefined -> ports and counters absent, behaviour otherwise identical.

Test Plan:
Reset release, imem_req_ready=1, 1-cycle response latency, dec_ready=1 -> requests at 0x200,0x204,0x208 in order; dec_pc follows 0x200,0x204,0x208, each with the matching data.
dec_ready=0 for 10 cycles -> exactly 2 requests issued, queue count 2, imem_req_valid stays 0; dec_ready=1 -> fetch resumes at 0x208.
pc_sel=PC_BRJMP, br_target=0x1000 while request to 0x20C outstanding -> 0x20C response discarded, next request addr 0x1000, dec_pc never shows 0x20C.
pc_sel=PC_EXC, exc_target=0x80 and dec_kill=1 with queue holding 2 entries -> dec_valid=0 next cycle, next request addr 0x80.
imem_res_valid in same cycle as pc_sel=PC_JALR, jalr_target=0x400 -> response dropped, next request 0x400.
rst_n asserted while request outstanding -> all outputs at reset values immediately; stale imem_res_valid after release ignored; first request 0x200.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC generation, single-outstanding imem requester and 2-entry decode queue.
// Define FETCH_PERF_EN to add the perf_fetched / perf_dropped counters.
module fetch_pc_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0200),
  parameter int              QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      pc_sel,
  input  logic            if_kill,
  input  logic            dec_kill,
  input  logic [XLEN-1:0] br_target,
  input  logic [XLEN-1:0] jalr_target,
  input  logic [XLEN-1:0] exc_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_res_valid,
  input  logic [XLEN-1:0] imem_res_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_inst,
  output logic [XLEN-1:0] dec_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped
`endif
);

  localparam logic [1:0] PC_4     = 2'd0;
  localparam logic [1:0] PC_BRJMP = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DROP  = 2'd3;

  localparam logic [1:0] QMAX = 2'(QDEPTH);

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } q_ent_t;

  logic [1:0]      state, state_nxt;
  logic [XLEN-1:0] fetch_pc, req_pc, redir_pc;
  q_ent_t          q0, q1, q_new;
  logic [1:0]      q_cnt;
  logic            redirect, squash, outstanding, req_fire, res_take, push, pop, drop;

  assign redirect = (pc_sel != PC_4);
  // if_kill on its own never squashes; it only matters alongside a redirect
  assign squash      = redirect | (if_kill & redirect);
  assign outstanding = (state == S_WAIT) || (state == S_DROP);

  assign imem_req_valid = (state == S_FETCH) && !redirect && ((q_cnt + {1'b0, outstanding}) < QMAX);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign res_take = imem_res_valid && outstanding;
  assign push     = res_take && (state == S_WAIT) && !squash && !dec_kill;
  assign drop     = res_take && !push;
  assign pop      = dec_valid && dec_ready && !dec_kill;
  assign q_new    = '{inst: imem_res_data, pc: req_pc};

  always_comb begin
    redir_pc = exc_target;
    if (pc_sel == PC_BRJMP)     redir_pc = br_target;
    else if (pc_sel == PC_JALR) redir_pc = jalr_target;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT:  state_nxt = S_FETCH;
      S_FETCH: if (req_fire) state_nxt = S_WAIT;
      // a response landing in the redirect cycle is consumed (and dropped) right away
      S_WAIT:  if (imem_res_valid) state_nxt = S_FETCH;
               else if (squash) state_nxt = S_DROP;
      S_DROP:  if (imem_res_valid) state_nxt = S_FETCH;
      default: state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_BOOT;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else begin
      state <= state_nxt;
      if (redirect)      fetch_pc <= redir_pc;
      else if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
      if (req_fire)      req_pc   <= fetch_pc;
    end
  end

  // q0 is always the head; a pop shifts q1 down
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_cnt <= '0;
      q0    <= '0;
      q1    <= '0;
    end else if (dec_kill) begin
      q_cnt <= '0;
    end else begin
      if (pop) q0 <= q1;
      if (push) begin
        if (q_cnt == 2'd0 || (q_cnt == 2'd1 && pop)) q0 <= q_new;
        else                                         q1 <= q_new;
      end
      q_cnt <= q_cnt + 2'(push) - 2'(pop);
    end
  end

  assign dec_valid = (q_cnt != 2'd0);
  assign dec_inst  = dec_valid ? q0.inst : '0;
  assign dec_pc    = dec_valid ? q0.pc   : '0;

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && q_cnt == QMAX));

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(push);
      perf_dropped <= perf_dropped + 32'(drop);
    end
  end
`endif

endmodule
